// File: rtl/timer_pkg.sv
// Shared constants for the countdown timer: FSM state codes and BCD digit geometry.
package timer_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StEntry = 3'd1;
    localparam logic [2:0] StLoad  = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StPause = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    localparam int unsigned DigitW = 4;
    localparam logic [DigitW-1:0] MaxDigit = 4'd9;

    function automatic logic is_digit(input logic [DigitW-1:0] code);
        return code <= MaxDigit;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/button and counter-cascade signals of the timer controller.
// master = front-end plus counter chain, slave = timer_ctrl.
interface timer_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 3
) ();

    logic                                     key_valid;
    logic [timer_pkg::DigitW-1:0]             key_code;
    logic                                     start;
    logic                                     stop;
    logic                                     zero;
    logic [timer_pkg::DigitW*NUM_DIGITS-1:0]  data;
    logic                                     load;
    logic                                     enable;
    logic                                     clear_out;
    logic                                     running;
    logic                                     done;

    modport master (
        output key_valid, key_code, start, stop, zero,
        input  data, load, enable, clear_out, running, done
    );

    modport slave (
        input  key_valid, key_code, start, stop, zero,
        output data, load, enable, clear_out, running, done
    );

endinterface

// File: rtl/tick_gen.sv
// Tick divider: counts 0..TICK_DIV-1 while inc_i is high, wrap_o flags the wrapping cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic clear,
    input  logic inc_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign wrap_o = inc_i && !clr_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: keypad entry, load/enable/clear of a BCD counter cascade.
// Build option TIMER_CTRL_BLINK_EN makes done blink at the tick rate while in DONE.
module timer_ctrl import timer_pkg::*; #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned TICK_DIV   = 50000000
) (
    input logic         clk,
    input logic         clear,
    timer_ctrl_if.slave bus_io
);

    localparam int unsigned EntryW = DigitW * NUM_DIGITS;

    logic [2:0]        state_q, state_d;
    logic [EntryW-1:0] entry_q, entry_d;
    logic              load_q, load_d;
    logic              enable_q, enable_d;
    logic              clear_out_q, clear_out_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    logic              tick_inc, tick_clr, tick_wrap;
    logic              key_ok, start_req, stop_req;
    logic [EntryW-1:0] entry_shift;

    assign stop_req    = bus_io.stop;
    assign start_req   = bus_io.start && !bus_io.stop;
    assign key_ok      = bus_io.key_valid && is_digit(bus_io.key_code) &&
                         ((state_q == StIdle) || (state_q == StEntry));
    assign entry_shift = (entry_q << DigitW) | EntryW'(bus_io.key_code);

    // Counter is already 0 in LOAD, so LOAD counts as the first tick cycle;
    // this makes the first enable land TICK_DIV cycles after load goes low.
    always_comb begin
        tick_inc = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            StLoad:  tick_inc = 1'b1;
            StRun:   tick_inc = !bus_io.zero && !bus_io.stop;
            StPause: tick_clr = bus_io.stop;
`ifdef TIMER_CTRL_BLINK_EN
            StDone: begin
                tick_clr = bus_io.start || bus_io.stop;
                tick_inc = !(bus_io.start || bus_io.stop);
            end
`else
            StDone:  tick_clr = 1'b1;
`endif
            default: tick_clr = 1'b1;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .clear  (clear),
        .inc_i  (tick_inc),
        .clr_i  (tick_clr),
        .wrap_o (tick_wrap)
    );

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        load_d      = 1'b1;
        enable_d    = 1'b0;
        clear_out_d = 1'b1;
        done_d      = done_q;

        case (state_q)
            StIdle: begin
                if (key_ok) begin
                    entry_d = entry_shift;
                    state_d = StEntry;
                end
            end
            StEntry: begin
                if (stop_req) begin
                    state_d     = StIdle;
                    entry_d     = '0;
                    clear_out_d = 1'b0;
                end else if (start_req && (entry_q != '0)) begin
                    state_d = StLoad;
                    load_d  = 1'b0;
                end else if (key_ok) begin
                    entry_d = entry_shift;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                // zero wins over a tick so the cascade never wraps past 0
                if (bus_io.zero) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (stop_req) begin
                    state_d = StPause;
                end else begin
                    enable_d = tick_wrap;
                end
            end
            StPause: begin
                if (stop_req) begin
                    state_d     = StIdle;
                    entry_d     = '0;
                    clear_out_d = 1'b0;
                end else if (start_req) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (bus_io.start || bus_io.stop) begin
                    state_d     = StIdle;
                    entry_d     = '0;
                    clear_out_d = 1'b0;
                    done_d      = 1'b0;
                end else if (tick_wrap) begin
                    done_d = !done_q;
                end
            end
            default: begin
                state_d = StIdle;
                entry_d = '0;
                done_d  = 1'b0;
            end
        endcase

        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q     <= StIdle;
            entry_q     <= '0;
            load_q      <= 1'b1;
            enable_q    <= 1'b0;
            clear_out_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            load_q      <= load_d;
            enable_q    <= enable_d;
            clear_out_q <= clear_out_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign bus_io.data      = entry_q;
    assign bus_io.load      = load_q;
    assign bus_io.enable    = enable_q;
    assign bus_io.clear_out = clear_out_q;
    assign bus_io.running   = running_q;
    assign bus_io.done      = done_q;

    // Cascade strobes are mutually exclusive.
    a_load_enable_excl: assert property (@(posedge clk) disable iff (!clear)
        !(enable_q && !load_q));
    a_clear_enable_excl: assert property (@(posedge clk) disable iff (!clear)
        !(enable_q && !clear_out_q));

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a decimal-arithmetic reference model and counter cascade.
module tb_timer_ctrl;

    localparam int ND  = 3;
    localparam int TD  = 4;
    localparam int Mod = 10 ** ND;

    localparam int MIdle  = 0;
    localparam int MEntry = 1;
    localparam int MLoad  = 2;
    localparam int MRun   = 3;
    localparam int MPause = 4;
    localparam int MDone  = 5;

    logic clk   = 1'b0;
    logic clear = 1'b0;

    int checks   = 0;
    int failures = 0;

    timer_ctrl_if #(.NUM_DIGITS(ND)) ifc ();

    timer_ctrl #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .bus_io (ifc)
    );

    always #5 clk = ~clk;

    // Counter cascade environment, value kept as a plain integer.
    int casc = 0;
    assign ifc.zero = (casc == 0);

    function automatic int from_bcd(input logic [4*ND-1:0] v);
        int r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!ifc.clear_out)   casc <= 0;
        else if (!ifc.load)   casc <= from_bcd(ifc.data);
        else if (ifc.enable)  casc <= (casc == 0) ? Mod - 1 : casc - 1;
    end

    // Reference model: entry as a decimal number, tick phase as count of timed cycles.
    int              m_mode  = MIdle;
    int              m_entry = 0;
    int              m_ticks = 0;
    bit              m_valid = 1'b0;
    logic [4*ND-1:0] e_data  = '0;
    logic            e_load  = 1'b1;
    logic            e_en    = 1'b0;
    logic            e_clr   = 1'b1;
    logic            e_run   = 1'b0;
    logic            e_done  = 1'b0;

    task automatic m_abort();
        m_mode  = MIdle;
        m_entry = 0;
        e_clr   = 1'b0;
        e_done  = 1'b0;
    endtask

    task automatic model_step();
        bit so, sa, dig, zr;
        so  = ifc.stop;
        sa  = ifc.start && !ifc.stop;
        dig = ifc.key_valid && (ifc.key_code <= 4'd9);
        zr  = (casc == 0);
        if (!clear) begin
            m_mode = MIdle; m_entry = 0; m_ticks = 0;
            e_load = 1'b1; e_en = 1'b0; e_clr = 1'b1; e_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            e_load = 1'b1; e_en = 1'b0; e_clr = 1'b1;
            case (m_mode)
                MIdle: if (dig) begin
                    m_entry = (m_entry * 10 + int'(ifc.key_code)) % Mod;
                    m_mode  = MEntry;
                end
                MEntry: begin
                    if (so) m_abort();
                    else if (sa && m_entry != 0) begin
                        m_mode = MLoad; e_load = 1'b0; m_ticks = 0;
                    end else if (dig) m_entry = (m_entry * 10 + int'(ifc.key_code)) % Mod;
                end
                MLoad: begin
                    m_mode  = MRun;
                    m_ticks = m_ticks + 1;
                end
                MRun: begin
                    if (zr) begin
                        m_mode = MDone; e_done = 1'b1;
                    end else if (so) m_mode = MPause;
                    else begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks % TD == 0) e_en = 1'b1;
                    end
                end
                MPause: begin
                    if (so) m_abort();
                    else if (sa) m_mode = MRun;
                end
                MDone: begin
                    if (ifc.stop || ifc.start) m_abort();
`ifdef TIMER_CTRL_BLINK_EN
                    else begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks % TD == 0) e_done = !e_done;
                    end
`endif
                end
                default: m_mode = MIdle;
            endcase
        end
        e_run  = (m_mode == MRun);
        e_data = to_bcd(m_entry);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("cyc_data",      32'(ifc.data),      32'(e_data));
            check("cyc_load",      32'(ifc.load),      32'(e_load));
            check("cyc_enable",    32'(ifc.enable),    32'(e_en));
            check("cyc_clear_out", 32'(ifc.clear_out), 32'(e_clr));
            check("cyc_running",   32'(ifc.running),   32'(e_run));
            check("cyc_done",      32'(ifc.done),      32'(e_done));
        end
    end

    task automatic press(input int k);
        ifc.key_valid = 1'b1;
        ifc.key_code  = 4'(k);
        @(negedge clk);
        ifc.key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic pulse_stop();
        ifc.stop = 1'b1;
        @(negedge clk);
        ifc.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_n, en_t[4], first_done, cnt, t1, t2, t_prev;
        logic prev;

        ifc.key_valid = 1'b0;
        ifc.key_code  = 4'd0;
        ifc.start     = 1'b0;
        ifc.stop      = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_data",      32'(ifc.data), 32'h0);
        check("rst_load",      32'(ifc.load), 32'h1);
        check("rst_enable",    32'(ifc.enable), 32'h0);
        check("rst_clear_out", 32'(ifc.clear_out), 32'h1);
        check("rst_done",      32'(ifc.done), 32'h0);
        check("rst_running",   32'(ifc.running), 32'h0);
        clear = 1'b1;
        @(negedge clk);

        // Entry with overflow and an ignored code, then cancel
        press(1); press(2); press(5); press(7); press(12);
        check("entry_257", 32'(ifc.data), 32'h257);
        pulse_stop();
        check("cancel_clear_low", 32'(ifc.clear_out), 32'h0);
        check("cancel_data",      32'(ifc.data), 32'h0);
        @(negedge clk);
        check("cancel_clear_1cyc", 32'(ifc.clear_out), 32'h1);

        // Full run from 3
        press(3);
        check("entry_3", 32'(ifc.data), 32'h003);
        pulse_start();
        check("load_low", 32'(ifc.load), 32'h0);
        en_n = 0; first_done = -1;
        for (int i = 0; i < 4; i++) en_t[i] = -1;
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            if (rel == 1) check("load_1cyc", 32'(ifc.load), 32'h1);
            if (ifc.enable) begin
                if (en_n < 4) en_t[en_n] = rel;
                en_n++;
            end
            if (ifc.done && first_done < 0) first_done = rel;
        end
        check("run_enable_count", 32'(en_n), 32'd3);
        check("run_enable_0", 32'(en_t[0]), 32'd4);
        check("run_enable_1", 32'(en_t[1]), 32'd8);
        check("run_enable_2", 32'(en_t[2]), 32'd12);
        check("run_done_at",  32'(first_done), 32'd14);
        pulse_stop();
        check("done_cleared", 32'(ifc.done), 32'h0);
        check("done_clear_pulse", 32'(ifc.clear_out), 32'h0);

        // Pause with tick phase 2, resume
        press(9);
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_stop();
        check("pause_running", 32'(ifc.running), 32'h0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.enable) cnt++;
        end
        check("pause_no_enable", 32'(cnt), 32'd0);
        pulse_start();
        check("resume_running", 32'(ifc.running), 32'h1);
        @(negedge clk);
        check("resume_en_early", 32'(ifc.enable), 32'h0);
        @(negedge clk);
        check("resume_en_2cyc", 32'(ifc.enable), 32'h1);

        // start+stop together in RUN pauses rather than cancels
        ifc.start = 1'b1;
        ifc.stop  = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        check("both_paused", 32'(ifc.running), 32'h0);
        check("both_no_clear", 32'(ifc.clear_out), 32'h1);
        pulse_stop();
        check("pause_cancel_clear", 32'(ifc.clear_out), 32'h0);

        // start with nothing entered
        pulse_start();
        check("idle_start_noload", 32'(ifc.load), 32'h1);
        press(0);
        pulse_start();
        check("zero_start_noload", 32'(ifc.load), 32'h1);
        @(negedge clk);
        check("zero_start_noload2", 32'(ifc.load), 32'h1);
        pulse_stop();
        check("zero_entry_cancel", 32'(ifc.clear_out), 32'h0);

        // Reset mid-run
        press(5);
        pulse_start();
        repeat (6) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("midrst_running", 32'(ifc.running), 32'h0);
        check("midrst_enable",  32'(ifc.enable), 32'h0);
        check("midrst_data",    32'(ifc.data), 32'h0);
        clear = 1'b1;
        @(negedge clk);

        // DONE hold / blink
        press(1);
        pulse_start();
        for (int i = 0; i < 40 && !ifc.done; i++) @(negedge clk);
        check("done_reached", 32'(ifc.done), 32'h1);
`ifdef TIMER_CTRL_BLINK_EN
        t1 = -1; t2 = -1; prev = ifc.done;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ifc.done != prev) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            prev = ifc.done;
        end
        check("blink_period", 32'(t2 - t1), 32'd4);
        t_prev = t1;
`else
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ifc.done) cnt++;
        end
        check("done_steady", 32'(cnt), 32'd12);
        t_prev = 0;
`endif
        pulse_start();
        check("done_start_exit", 32'(ifc.done), 32'h0);
        check("done_start_clear", 32'(ifc.clear_out), 32'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
